posit_decode_pipe: RTL and testbench

//  2-stage pipelined posit field extractor with valid/ready handshake; sits directly upstream of the ppu arithmetic core.

---
 rtl/posit_decode_pipe_if.sv | 44 ++++
 rtl/posit_decode_pipe.sv | 154 +++++++++++++++
 tb/tb_posit_decode_pipe.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/posit_decode_pipe_if.sv
// Handshake bundle between a posit producer (master) and posit_decode_pipe (slave).
// `define PPU_DECODE_SCALE_EN adds out_scale to the bundle.
interface posit_decode_pipe_if #(
  parameter int N  = 32,
  parameter int es = 2
);
  localparam int RW = $clog2(N) + 1;
  localparam int MW = N - es - 1;
  // es=0 keeps a one-bit exponent field so the port list stays legal
  localparam int EW = (es > 0) ? es : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         in_posit;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic                 out_zero;
  logic                 out_nar;
  logic signed [RW-1:0] out_k;
  logic [EW-1:0]        out_exp;
  logic [MW-1:0]        out_mant;
`ifdef PPU_DECODE_SCALE_EN
  logic signed [RW+es-1:0] out_scale;

  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_sign, out_zero, out_nar, out_k, out_exp, out_mant, out_scale
  );
  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_sign, out_zero, out_nar, out_k, out_exp, out_mant, out_scale
  );
`else
  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_sign, out_zero, out_nar, out_k, out_exp, out_mant
  );
  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_sign, out_zero, out_nar, out_k, out_exp, out_mant
  );
`endif
endinterface

// File: rtl/posit_decode_pipe.sv
// Posit -> {sign, k, exp, mant, zero, nar}; 2 cycles accept->out_valid, 1/cycle, in_ready drops only with both stages full.
// `define PPU_DECODE_SCALE_EN to add out_scale = (k << es) + exp, registered with the other outputs.
module posit_decode_pipe #(
  parameter int N  = 32,
  parameter int es = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  posit_decode_pipe_if.slave bus
);
  localparam int RW = $clog2(N) + 1;
  localparam int MW = N - es - 1;
  localparam int EW = (es > 0) ? es : 1;
  localparam int FW = N - es - 2;

  logic s1_en;
  logic s2_en;

  logic          s1_valid;
  logic          s1_sign;
  logic          s1_zero;
  logic          s1_nar;
  logic          s1_rc;
  logic [RW-1:0] s1_run;
  logic [N-3:0]  s1_body;

  logic                 o_valid;
  logic                 o_sign;
  logic                 o_zero;
  logic                 o_nar;
  logic signed [RW-1:0] o_k;
  logic [EW-1:0]        o_exp;
  logic [MW-1:0]        o_mant;

  assign s2_en        = ~o_valid | bus.out_ready;
  assign s1_en        = ~s1_valid | s2_en;
  assign bus.in_ready = s1_en;

  // Stage 1: magnitude and regime run length
  logic [N-2:0]  xin;
  logic          rc;
  logic [RW-1:0] run;
  logic          stop;

  always_comb begin
    xin  = bus.in_posit[N-1] ? -bus.in_posit[N-2:0] : bus.in_posit[N-2:0];
    rc   = xin[N-2];
    run  = '0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && (xin[i] == rc)) run = run + RW'(1);
      else                         stop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_rc    <= 1'b0;
      s1_run   <= '0;
      s1_body  <= '0;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign <= bus.in_posit[N-1];
        s1_zero <= (bus.in_posit == '0);
        s1_nar  <= (bus.in_posit == {1'b1, {(N-1){1'b0}}});
        s1_rc   <= rc;
        s1_run  <= run;
        // xin[N-2] is the first regime bit and always falls off the top of the shift
        s1_body <= xin[N-3:0];
      end
    end
  end

  // Stage 2: shifting the body by run lands exp/frac right after the terminator
  logic [N-3:0]         fields;
  logic signed [RW-1:0] nx_k;
  logic [EW-1:0]        nx_exp;
  logic [FW-1:0]        nx_frac;

  always_comb begin
    nx_k   = s1_rc ? $signed(s1_run - RW'(1)) : $signed(-s1_run);
    fields = (s1_run == RW'(N - 1)) ? '0 : (s1_body << s1_run);
  end

  generate
    if (es > 0) begin : g_exp
      assign {nx_exp, nx_frac} = fields;
    end else begin : g_noexp
      assign nx_exp  = '0;
      assign nx_frac = fields;
    end
  endgenerate

`ifdef PPU_DECODE_SCALE_EN
  logic signed [RW+es-1:0] nx_scale;
  logic signed [RW+es-1:0] o_scale;

  always_comb begin
    nx_scale = ((RW + es)'(nx_k) <<< es) + (RW + es)'(nx_exp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_scale <= '0;
    end else if (s2_en && s1_valid) begin
      o_scale <= (s1_zero || s1_nar) ? '0 : nx_scale;
    end
  end

  assign bus.out_scale = o_scale;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_sign  <= 1'b0;
      o_zero  <= 1'b0;
      o_nar   <= 1'b0;
      o_k     <= '0;
      o_exp   <= '0;
      o_mant  <= '0;
    end else if (s2_en) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_sign <= s1_sign;
        o_zero <= s1_zero;
        o_nar  <= s1_nar;
        if (s1_zero || s1_nar) begin
          o_k    <= '0;
          o_exp  <= '0;
          o_mant <= '0;
        end else begin
          o_k    <= nx_k;
          o_exp  <= nx_exp;
          o_mant <= {1'b1, nx_frac};
        end
      end
    end
  end

  assign bus.out_valid = o_valid;
  assign bus.out_sign  = o_sign;
  assign bus.out_zero  = o_zero;
  assign bus.out_nar   = o_nar;
  assign bus.out_k     = o_k;
  assign bus.out_exp   = o_exp;
  assign bus.out_mant  = o_mant;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Directed-vector bench for posit_decode_pipe at N=32, es=2 with an in-order scoreboard.
module tb_posit_decode_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  posit_decode_pipe_if #(.N(32), .es(2)) bus ();

  posit_decode_pipe #(.N(32), .es(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] p;
    int          s;
    int          z;
    int          n;
    int          k;
    int          e;
    int          m;
    int          sc;
  } vec_t;

  vec_t vt[10];
  int   exp_q[$];
  int   acc_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cur_idx = 0;
  int   acc = 0;
  int   n_acc = 0;
  int   n_del = 0;
  int   last_lat = 0;
  int   held = 0;
  int   hold_mant = 0;
  int   hold_k = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  task automatic deliver();
    int idx;
    int ac;
    if (exp_q.size() == 0) begin
      chk("spurious_out", 1, 0);
      return;
    end
    idx = exp_q.pop_front();
    ac  = acc_q.pop_front();
    last_lat = cyc - ac;
    n_del++;
    chk($sformatf("sign[%0d]", idx), int'(bus.out_sign), vt[idx].s);
    chk($sformatf("zero[%0d]", idx), int'(bus.out_zero), vt[idx].z);
    chk($sformatf("nar[%0d]", idx),  int'(bus.out_nar),  vt[idx].n);
    chk($sformatf("k[%0d]", idx),    int'(bus.out_k),    vt[idx].k);
    chk($sformatf("exp[%0d]", idx),  int'(bus.out_exp),  vt[idx].e);
    chk($sformatf("mant[%0d]", idx), int'(bus.out_mant), vt[idx].m);
`ifdef PPU_DECODE_SCALE_EN
    chk($sformatf("scale[%0d]", idx), int'(bus.out_scale), vt[idx].sc);
`endif
  endtask

  // One cycle: inputs were set at the preceding negedge; sample, then cross the next posedge.
  task automatic step();
    #2;
    acc = 0;
    if (held != 0) begin
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_mant",  int'(bus.out_mant), hold_mant);
      chk("hold_k",     int'(bus.out_k), hold_k);
    end
    if (rst_n && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(cur_idx);
      acc_q.push_back(cyc);
      acc = 1;
      n_acc++;
    end
    if (rst_n && bus.out_valid && bus.out_ready) deliver();
    held      = (bus.out_valid && !bus.out_ready) ? 1 : 0;
    hold_mant = int'(bus.out_mant);
    hold_k    = int'(bus.out_k);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input int idx);
    int ok;
    ok = 0;
    cur_idx = idx;
    bus.in_posit = vt[idx].p;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 20 && ok == 0; t++) begin
      step();
      ok = acc;
    end
    if (ok == 0) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() > 0; t++) step();
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int c0;
    int d0;
    int bp_list[4];
    int a;

    vt[0] = '{32'h4000_0000, 0, 0, 0,   0, 0, 32'h1000_0000,    0};
    vt[1] = '{32'h4800_0000, 0, 0, 0,   0, 1, 32'h1000_0000,    1};
    vt[2] = '{32'hC000_0000, 1, 0, 0,   0, 0, 32'h1000_0000,    0};
    vt[3] = '{32'h0000_0001, 0, 0, 0, -30, 0, 32'h1000_0000, -120};
    vt[4] = '{32'h7FFF_FFFF, 0, 0, 0,  30, 0, 32'h1000_0000,  120};
    vt[5] = '{32'h0000_0000, 0, 1, 0,   0, 0, 0,                0};
    vt[6] = '{32'h8000_0000, 1, 0, 1,   0, 0, 0,                0};
    vt[7] = '{32'h5A00_0000, 0, 0, 0,   0, 3, 32'h1400_0000,    3};
    vt[8] = '{32'h1C00_0000, 0, 0, 0,  -2, 3, 32'h1000_0000,   -5};
    vt[9] = '{32'h7FFF_FFFE, 0, 0, 0,  29, 0, 32'h1000_0000,  116};

    bus.in_valid  = 1'b0;
    bus.in_posit  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_k",     int'(bus.out_k), 0);
    chk("rst_out_mant",  int'(bus.out_mant), 0);
    chk("rst_out_flags", int'({bus.out_sign, bus.out_zero, bus.out_nar}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);

    // Single transfer latency
    bus.out_ready = 1'b1;
    send(0);
    drain();
    chk("latency", last_lat, 2);

    // Back-to-back stream of every vector at full throughput
    c0 = cyc;
    for (int i = 0; i < 10; i++) send(i);
    chk("throughput_cycles", cyc - c0, 10);
    drain();

    // Backpressure: two entries buffered, then everything drains in order
    bp_list = '{1, 3, 6, 8};
    bus.out_ready = 1'b0;
    a  = 0;
    d0 = n_del;
    c0 = n_acc;
    cur_idx = bp_list[0];
    bus.in_posit = vt[cur_idx].p;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      step();
      if (acc != 0) begin
        a++;
        cur_idx = bp_list[a];
        bus.in_posit = vt[cur_idx].p;
      end
    end
    chk("bp_accepts", n_acc - c0, 2);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20 && a < 4; t++) begin
      step();
      if (acc != 0) begin
        a++;
        if (a < 4) begin
          cur_idx = bp_list[a];
          bus.in_posit = vt[cur_idx].p;
        end
      end
    end
    drain();
    chk("bp_delivered", n_del - d0, 4);

    // Reset with both stages full: contents discarded
    bus.out_ready = 1'b0;
    send(7);
    send(9);
    bus.in_valid = 1'b0;
    step();
    chk("full_before_rst", int'(bus.in_ready), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", int'(bus.out_valid), 0);
    exp_q.delete();
    acc_q.delete();
    held = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    d0 = n_del;
    repeat (4) step();
    chk("no_stale_out", n_del - d0, 0);
    chk("no_stale_valid", int'(bus.out_valid), 0);

    // Pipeline still works after the reset
    send(8);
    drain();
    chk("post_rst_latency", last_lat, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
